// File: rtl/demod_uart_streamer_pkg.sv
// demod_uart_streamer_pkg: shared command words, header nibble and FSM encodings for the demod streamer
package demod_uart_streamer_pkg;
  localparam logic [7:0] DEF_BASE_CMD = 8'h06;
  localparam logic [7:0] DEF_SCAN_CMD = 8'h0F;
  localparam logic [3:0] HDR_NIB      = 4'hA;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ARM  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_SEND = 3'd3;
  localparam logic [2:0] ST_NEXT = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;
  localparam logic [1:0] HS_IDLE = 2'd0;
  localparam logic [1:0] HS_WAIT = 2'd1;
  localparam logic [1:0] HS_LOCK = 2'd2;
  localparam logic [1:0] HS_GAP  = 2'd3;
  function automatic logic [7:0] hdr_byte(input logic [3:0] ch);
    return {HDR_NIB, ch};
  endfunction
endpackage

// File: rtl/demod_uart_streamer_uart_byte_hs.sv
// demod_uart_streamer_uart_byte_hs: per-byte load / wait-for-UART / lock strobe / guard-gap handshake
module demod_uart_streamer_uart_byte_hs
  import demod_uart_streamer_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_abort,
  input  logic       i_go,
  input  logic [7:0] i_byte,
  input  logic       i_uart_avl,
  output logic [7:0] o_uart_send,
  output logic       o_uart_dat_lock,
  output logic       o_byte_done
);
  logic [1:0] r_state;
  assign o_uart_dat_lock = r_state == HS_LOCK;
  assign o_byte_done     = r_state == HS_GAP;
  // the gap cycle after the lock lets the UART drop UARTAvl before the next byte is offered
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= HS_IDLE;
      o_uart_send <= 8'd0;
    end else if (i_abort) begin
      r_state     <= HS_IDLE;
      o_uart_send <= 8'd0;
    end else if (i_go) begin
      r_state     <= HS_WAIT;
      o_uart_send <= i_byte;
    end else begin
      r_state <= (r_state == HS_WAIT && i_uart_avl) ? HS_LOCK :
                 (r_state == HS_LOCK)               ? HS_GAP  :
                 (r_state == HS_GAP)                ? HS_IDLE : r_state;
    end
  end
endmodule

// File: rtl/demod_uart_streamer.sv
// demod_uart_streamer: requests demod results per command and streams them MSB-first to the UART
module demod_uart_streamer
  import demod_uart_streamer_pkg::*;
#(
  parameter int         NUM_CH   = 2,
  parameter int         RES_W    = 32,
  parameter logic [7:0] BASE_CMD = DEF_BASE_CMD,
  parameter logic [7:0] SCAN_CMD = DEF_SCAN_CMD,
  parameter bit         HDR_EN   = 1'b1,
  parameter int         TIMEOUT  = 1000000
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [7:0]              i_sys_state,
  input  logic                    i_enable,
  input  logic [7:0]              i_sample_cnt,
  output logic                    o_done,
  output logic                    o_busy,
  output logic                    o_err,
  output logic [NUM_CH-1:0]       o_demod_en,
  input  logic [NUM_CH-1:0]       i_demod_ready,
  input  logic [NUM_CH*RES_W-1:0] i_demod_result,
  input  logic                    i_uart_avl,
  output logic [7:0]              o_uart_send,
  output logic                    o_uart_dat_lock
);
  localparam int         NBYTES  = RES_W / 8;
  localparam int         TW      = $clog2(TIMEOUT + 1);
  localparam int         BW      = $clog2(NBYTES + 1);
  localparam logic [3:0] LAST_CH = 4'(NUM_CH - 1);
  logic [2:0]        r_state;
  logic              r_scan;
  logic [3:0]        r_ch;
  logic [3:0]        r_ch0;
  logic [7:0]        r_samples;
  logic [RES_W-1:0]  r_shreg;
  logic [BW-1:0]     r_bytes;
  logic [TW-1:0]     r_tmo;
  logic              r_err;
  logic [7:0]        w_off;
  logic              w_scan_cmd;
  logic              w_match;
  logic [NUM_CH-1:0] w_onehot;
  logic [RES_W-1:0]  w_res;
  logic              w_ready;
  logic              w_got;
  logic              w_more;
  logic              w_go;
  logic [7:0]        w_byte;
  logic              w_byte_done;
  assign w_off      = i_sys_state - BASE_CMD;
  assign w_scan_cmd = i_sys_state == SCAN_CMD;
  assign w_match    = w_scan_cmd || (w_off < 8'(NUM_CH));
  always_comb begin
    w_onehot = '0;
    w_res    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_onehot[i] = r_ch == 4'(i);
      if (r_ch == 4'(i)) w_res = i_demod_result[i*RES_W +: RES_W];
    end
  end
  assign w_ready = |(i_demod_ready & w_onehot);
  assign w_got   = r_state == ST_WAIT && w_ready;
  assign w_more  = r_state == ST_SEND && w_byte_done && r_bytes != '0;
  assign w_go    = i_enable && (w_got || w_more);
  assign w_byte  = !w_got ? r_shreg[RES_W-1 -: 8] : HDR_EN ? hdr_byte(r_ch) : w_res[RES_W-1 -: 8];
  assign o_demod_en = (r_state == ST_WAIT) ? w_onehot : '0;
  assign o_done     = r_state == ST_DONE;
  assign o_busy     = r_state != ST_IDLE && r_state != ST_DONE;
  assign o_err      = r_err;
  demod_uart_streamer_uart_byte_hs u_hs (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_abort        (!i_enable),
    .i_go           (w_go),
    .i_byte         (w_byte),
    .i_uart_avl     (i_uart_avl),
    .o_uart_send    (o_uart_send),
    .o_uart_dat_lock(o_uart_dat_lock),
    .o_byte_done    (w_byte_done)
  );
  // the first byte leaves with the WAIT->SEND edge, so the shift register starts one byte ahead without a header
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_scan    <= 1'b0;
      r_ch      <= 4'd0;
      r_ch0     <= 4'd0;
      r_samples <= 8'd0;
      r_shreg   <= '0;
      r_bytes   <= '0;
      r_tmo     <= '0;
      r_err     <= 1'b0;
    end else if (!i_enable) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_match) begin
          r_state   <= ST_ARM;
          r_scan    <= w_scan_cmd;
          r_ch      <= w_scan_cmd ? 4'd0 : w_off[3:0];
          r_ch0     <= w_scan_cmd ? 4'd0 : w_off[3:0];
          r_samples <= (i_sample_cnt == 8'd0) ? 8'd1 : i_sample_cnt;
          r_err     <= 1'b0;
        end
        ST_ARM: begin
          r_tmo   <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: if (w_ready) begin
          r_shreg <= HDR_EN ? w_res : w_res << 8;
          r_bytes <= HDR_EN ? BW'(NBYTES) : BW'(NBYTES - 1);
          r_state <= ST_SEND;
        end else if (r_tmo == TW'(TIMEOUT - 1)) begin
          r_err   <= 1'b1;
          r_state <= ST_DONE;
        end else begin
          r_tmo <= r_tmo + 1'b1;
        end
        ST_SEND: if (w_byte_done) begin
          if (r_bytes != '0) begin
            r_shreg <= r_shreg << 8;
            r_bytes <= r_bytes - 1'b1;
          end else begin
            r_state <= ST_NEXT;
          end
        end
        ST_NEXT: if (r_scan && r_ch != LAST_CH) begin
          r_ch    <= r_ch + 1'b1;
          r_state <= ST_ARM;
        end else if (r_samples > 8'd1) begin
          r_samples <= r_samples - 1'b1;
          r_ch      <= r_ch0;
          r_state   <= ST_ARM;
        end else begin
          r_state <= ST_DONE;
        end
        ST_DONE: r_state <= ST_DONE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule
